// File: rtl/conv_window_gen.sv
// Streaming KxK sliding-window generator: K-1 circular line buffers, a KxK window, stride control.
// Define CONV_WIN_POS_EN to add out_row/out_col output-map coordinates.
module conv_window_gen #(
    parameter int unsigned WIDTH       = 28,
    parameter int unsigned HEIGHT      = 28,
    parameter int unsigned DATA_BIT    = 8,
    parameter int unsigned KERNEL_SIZE = 5,
    parameter int unsigned STRIDE      = 1,
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    localparam int unsigned RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
    localparam int unsigned WW = KERNEL_SIZE * KERNEL_SIZE * DATA_BIT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [DATA_BIT-1:0] in_data,
    output logic                out_valid,
    output logic [WW-1:0]       out_win,
    output logic                out_last
`ifdef CONV_WIN_POS_EN
    ,
    output logic [RW-1:0]       out_row,
    output logic [CW-1:0]       out_col
`endif
);

    localparam int unsigned K      = KERNEL_SIZE;
    localparam int unsigned LBN    = (K > 1) ? K - 1 : 1;
    localparam int unsigned PW     = (LBN > 1) ? $clog2(LBN) : 1;
    localparam int unsigned SW     = $clog2(STRIDE + 1);
    localparam int unsigned LAST_R = (K - 1) + ((HEIGHT - K) / STRIDE) * STRIDE;
    localparam int unsigned LAST_C = (K - 1) + ((WIDTH - K) / STRIDE) * STRIDE;

    typedef logic [K-1:0][K-1:0][DATA_BIT-1:0] win_t;

    logic [DATA_BIT-1:0] lb_mem [LBN][WIDTH];

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [SW-1:0] col_cnt_q, col_cnt_d, row_cnt_q, row_cnt_d;
    logic [PW-1:0] wp_q, wp_d;
    win_t          win_q, win_d, out_win_q, out_win_d;
    logic          out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic          col_ge, row_ge, col_ok, row_ok, row_end, frame_end;
    logic [PW:0]   rd_slot;
    logic [K-1:0][DATA_BIT-1:0] col_in;
`ifdef CONV_WIN_POS_EN
    logic [RW-1:0] orow_q, orow_d, out_row_q, out_row_d;
    logic [CW-1:0] ocol_q, ocol_d, out_col_q, out_col_d;
`endif

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        col_cnt_d   = col_cnt_q;
        row_cnt_d   = row_cnt_q;
        wp_d        = wp_q;
        win_d       = win_q;
        out_win_d   = out_win_q;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        rd_slot     = '0;
`ifdef CONV_WIN_POS_EN
        orow_d      = orow_q;
        ocol_d      = ocol_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
`endif
        col_ge    = (CW + 1)'(col_q) + (CW + 1)'(1) >= (CW + 1)'(K);
        row_ge    = (RW + 1)'(row_q) + (RW + 1)'(1) >= (RW + 1)'(K);
        col_ok    = col_ge && (col_cnt_q == '0);
        row_ok    = row_ge && (row_cnt_q == '0);
        row_end   = (col_q == CW'(WIDTH - 1));
        frame_end = row_end && (row_q == RW'(HEIGHT - 1));

        // Slot wp_q holds the oldest buffered row; later rows follow circularly.
        for (int i = 0; i < int'(K); i++) col_in[i] = in_data;
        for (int i = 0; i < int'(K) - 1; i++) begin
            rd_slot = (PW + 1)'(wp_q) + (PW + 1)'(i);
            if (rd_slot >= (PW + 1)'(LBN)) rd_slot = rd_slot - (PW + 1)'(LBN);
            col_in[i] = lb_mem[PW'(rd_slot)][col_q];
        end

        if (in_valid) begin
            for (int i = 0; i < int'(K); i++) begin
                for (int j = 0; j < int'(K) - 1; j++) win_d[i][j] = win_q[i][j+1];
                win_d[i][K-1] = col_in[i];
            end

            if (col_ok && row_ok) begin
                out_valid_d = 1'b1;
                out_last_d  = (col_q == CW'(LAST_C)) && (row_q == RW'(LAST_R));
                out_win_d   = win_d;
`ifdef CONV_WIN_POS_EN
                out_row_d   = orow_q;
                out_col_d   = ocol_q;
`endif
            end
`ifdef CONV_WIN_POS_EN
            if (col_ok) ocol_d = ocol_q + CW'(1);
`endif

            if (row_end) begin
                col_d     = '0;
                col_cnt_d = '0;
                wp_d      = (wp_q == PW'(LBN - 1)) ? '0 : wp_q + PW'(1);
`ifdef CONV_WIN_POS_EN
                ocol_d    = '0;
                if (frame_end) orow_d = '0;
                else if (row_ok) orow_d = orow_q + RW'(1);
`endif
                if (frame_end) begin
                    row_d     = '0;
                    row_cnt_d = '0;
                end else begin
                    row_d = row_q + RW'(1);
                    if (row_ge) row_cnt_d = (row_cnt_q == '0) ? SW'(STRIDE - 1) : row_cnt_q - SW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
                if (col_ge) col_cnt_d = (col_cnt_q == '0) ? SW'(STRIDE - 1) : col_cnt_q - SW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            col_q       <= '0;
            row_q       <= '0;
            col_cnt_q   <= '0;
            row_cnt_q   <= '0;
            wp_q        <= '0;
            win_q       <= '0;
            out_win_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
`ifdef CONV_WIN_POS_EN
            orow_q      <= '0;
            ocol_q      <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
`endif
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            col_cnt_q   <= col_cnt_d;
            row_cnt_q   <= row_cnt_d;
            wp_q        <= wp_d;
            win_q       <= win_d;
            out_win_q   <= out_win_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
`ifdef CONV_WIN_POS_EN
            orow_q      <= orow_d;
            ocol_q      <= ocol_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
`endif
        end
    end

    // Line-buffer storage is deliberately left uninitialised across reset.
    always_ff @(posedge clk) begin
        if (in_valid && (K > 1)) lb_mem[wp_q][col_q] <= in_data;
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_win   = out_win_q;
`ifdef CONV_WIN_POS_EN
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
`endif

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Parametrised streaming K x K sliding-window generator for the CNN conv layers; next generation of the fixed 5x5 conv buffer.
- Accepts a raster-order pixel stream with a valid qualifier and keeps K-1 line buffers plus a K x K window register.
- Emits one full window per valid output position, with configurable kernel size and stride and an end-of-frame marker.
- Sits between the input image/feature-map source and the MAC array. Weight and bias storage moves to a separate block.

Parameters:
- WIDTH, 28, pixels per input row (>= KERNEL_SIZE)
- HEIGHT, 28, rows per input frame (>= KERNEL_SIZE)
- DATA_BIT, 8, bits per pixel
- KERNEL_SIZE, 5, window edge K (odd, 1..7)
- STRIDE, 1, output step in rows and columns (1..K)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous active-low reset; acts on rising clk when rst==0
- in_valid  in  1  in_data is a valid pixel this cycle
- in_data  in  DATA_BIT  pixel, raster order, row 0 col 0 first
- out_valid  out  1  out_win holds a valid window this cycle
- out_win  out  K*K*DATA_BIT  window; element (i,j) at bits [(i*K+j)*DATA_BIT +: DATA_BIT]; i=0 is the top (oldest) row, j=0 is the leftmost column
- out_last  out  1  qualifies out_valid; high on the final window of the frame

Behaviour:
- Reset (rst==0): out_valid=0, out_last=0, out_win=0, col/row counters=0. Line-buffer RAM is not cleared.
- Reset mid-frame: the next accepted pixel is treated as row 0 col 0. No window is emitted until K-1 full rows plus K pixels have been re-accepted.
- Accept: a pixel is consumed only when in_valid==1. When in_valid==0, all counters, line buffers and the window hold.
- Output timing: out_valid is forced to 0 in any cycle following in_valid==0. There is no backpressure.
- Each accepted pixel at (r,c):
  - shifts the window left by one column;
  - loads the new right column from the line buffers (rows r-K+1..r-1) plus in_data;
  - writes in_data into the line buffer at column c.
  - Line buffers are circular per column; there is no data copying between rows.
- Counters: c increments per accepted pixel and wraps WIDTH-1 -> 0 with r+1. r wraps HEIGHT-1 -> 0 at end of frame.
- Back-to-back frames are supported with no gap. The window contents straddling a frame boundary are never flagged valid.
- Emit condition for accepted pixel (r,c), all true:
  - r >= K-1 and c >= K-1
  - (r-(K-1)) mod STRIDE == 0
  - (c-(K-1)) mod STRIDE == 0
- Emit response: out_valid=1 the next cycle (latency 1) with the window whose bottom-right is (r,c).
- Windows never wrap across row ends: columns 0..K-2 of each row produce no output.
- out_last=1 together with the window emitted for the last valid (r,c) of the frame. Output count per frame = ((HEIGHT-K)/STRIDE+1)*((WIDTH-K)/STRIDE+1), using integer division.
- Stride counters are implemented as down-counters, not modulo arithmetic. Counter widths use $clog2(WIDTH) and $clog2(HEIGHT).
- out_win keeps its last value while out_valid==0.

Optional Feature:
- Macro: CONV_WIN_POS_EN.
- Defined: adds output ports out_row ($clog2(HEIGHT) bits) and out_col ($clog2(WIDTH) bits). They give the output-map coordinates (0-based, in stride units) of the current window, are valid with out_valid, and reset to 0.
- Undefined: ports and their logic are absent. All other behaviour is identical.

Test Plan:
- WIDTH=6, HEIGHT=5, K=3, STRIDE=1; pixel value = r*6+c, in_valid held high -> 12 windows.
  - First window one cycle after pixel 14 is accepted, with elements 0,1,2,6,7,8,12,13,14.
  - out_last on window 12 with elements 15,16,17,21,22,23,27,28,29.
- Same as above with in_valid toggling 1,0,1,0 -> identical window sequence; out_valid never high in a cycle after in_valid==0.
- WIDTH=7, HEIGHT=7, K=3, STRIDE=2; value = r*7+c -> 9 windows.
  - Bottom-right pixels (2,2),(2,4),(2,6),(4,2)...(6,6).
  - With CONV_WIN_POS_EN: out_row/out_col step 0..2.
- Default params (28x28, K=5, STRIDE=1), two back-to-back frames -> 576 windows per frame.
  - Frame 2's first window emitted after pixel (4,4) of frame 2, containing only frame-2 data.
  - out_last exactly once per frame.
- Reset asserted (rst=0) at pixel (10,3) of a 28x28 frame, then a fresh frame streamed -> out_valid=0 during and after reset until pixel (4,4) of the new frame; the first window contains only new-frame data.
- K=1, STRIDE=1, WIDTH=4, HEIGHT=2 -> 8 windows equal to the input pixels, delayed one cycle; out_last on the 8th.
